uart_boot_ctrl: RTL and testbench

Controller that sits between the UART receiver/transmitter and the CPU's instruction memory and run control. It parses the incoming ASCII byte stream into 32-bit instruction words, writes them sequentially into instruction memory, and echoes every byte. It also starts and stops the CPU on command and reports CPU halt back over the UART. It replaces ad-hoc nibble accumulation in the top level with a single sequenced owner of the load/run flow.

---
 rtl/uart_boot_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_boot_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_ctrl.sv
// UART boot controller: parses ASCII hex into instruction words,
// echoes every byte, and owns CPU start/stop and halt reporting.
module uart_boot_ctrl #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic              rx_rdy_clr,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_wr_en,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_start,
  input  logic              cpu_halt,
  output logic [ADDR_W:0]   load_count,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ECHO   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(WORDS);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [2:0]        nib_cnt;
  logic [31:0]       acc;
  logic              pend;
  logic              halt_q;

  logic              is_hex;
  logic              is_r;
  logic              is_g;
  logic              is_x;
  logic              is_ws;
  logic [3:0]        nib;
  logic              full;
  logic              halt_rise;

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    unique case (1'b1)
      (rx_data >= 8'h30 && rx_data <= 8'h39): begin
        is_hex = 1'b1;
        nib    = rx_data[3:0];
      end
      (rx_data >= 8'h41 && rx_data <= 8'h46),
      (rx_data >= 8'h61 && rx_data <= 8'h66): begin
        is_hex = 1'b1;
        nib    = rx_data[3:0] + 4'd9;
      end
      default: begin
        is_hex = 1'b0;
        nib    = 4'h0;
      end
    endcase
  end

  assign is_r  = (rx_data == 8'h52);
  assign is_g  = (rx_data == 8'h47);
  assign is_x  = (rx_data == 8'h58);
  assign is_ws = (rx_data == 8'h20) ||
                 (rx_data == 8'h0D) ||
                 (rx_data == 8'h0A);

  assign full      = (load_count == FULL_CNT);
  assign halt_rise = cpu_halt && !halt_q && cpu_start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (pend)        state_nx = ECHO;
        else if (rx_rdy) state_nx = DECODE;
      end
      DECODE: state_nx = ECHO;
      ECHO: begin
        if (!tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are gated by rst so an echo in flight is aborted cleanly.
  always_comb begin
    rx_rdy_clr = 1'b0;
    tx_wr_en   = 1'b0;
    if (!rst) begin
      rx_rdy_clr = (state == DECODE);
      tx_wr_en   = (state == ECHO) && !tx_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data    <= 8'h00;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      cpu_start  <= 1'b0;
      load_count <= '0;
      err        <= 1'b0;
      ptr        <= '0;
      nib_cnt    <= 3'd0;
      acc        <= 32'h0;
      pend       <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      halt_q  <= cpu_halt;
      if (halt_rise) pend <= 1'b1;
      if (state == IDLE && pend) begin
        tx_data <= 8'h48;
        pend    <= 1'b0;
      end
      if (state == DECODE) begin
        unique case (1'b1)
          is_hex: begin
            if (cpu_start || full) begin
              err     <= 1'b1;
              tx_data <= 8'h21;
            end else begin
              acc     <= {acc[27:0], nib};
              tx_data <= rx_data;
              if (nib_cnt == 3'd7) begin
                imem_we    <= 1'b1;
                imem_addr  <= ptr;
                imem_wdata <= {acc[27:0], nib};
                ptr        <= ptr + 1'b1;
                load_count <= load_count + 1'b1;
                nib_cnt    <= 3'd0;
              end else begin
                nib_cnt <= nib_cnt + 3'd1;
              end
            end
          end
          is_r: begin
            if (cpu_start) begin
              err     <= 1'b1;
              tx_data <= 8'h21;
            end else begin
              ptr        <= '0;
              load_count <= '0;
              nib_cnt    <= 3'd0;
              acc        <= 32'h0;
              err        <= 1'b0;
              tx_data    <= 8'h52;
            end
          end
          is_g: begin
            cpu_start <= 1'b1;
            nib_cnt   <= 3'd0;
            tx_data   <= 8'h47;
          end
          is_x: begin
            // Stopping wins over a halt edge in the same cycle.
            cpu_start <= 1'b0;
            pend      <= 1'b0;
            tx_data   <= 8'h58;
          end
          is_ws: tx_data <= rx_data;
          default: begin
            err     <= 1'b1;
            tx_data <= 8'h3F;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Bench for uart_boot_ctrl: vector table plus hand sequences,
// echoes and memory writes checked through scoreboard queues.
module tb_uart_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy = 1'b0;
  logic        rx_rdy_clr;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_start;
  logic        cpu_halt = 1'b0;
  logic [4:0]  load_count;
  logic        err;

  int checks = 0;
  int errors = 0;
  int echo_cnt = 0;

  logic [7:0]  q_echo[$];
  logic [35:0] q_wr[$];

  typedef struct {
    logic [7:0]  ch;
    logic [7:0]  echo;
    bit          we;
    logic [35:0] wr;
    bit          err;
    int          lc;
  } vec_t;

  vec_t tv[$];

  uart_boot_ctrl #(.WORDS(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .rx_rdy_clr(rx_rdy_clr),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_wr_en  (tx_wr_en),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_start (cpu_start),
    .cpu_halt  (cpu_halt),
    .load_count(load_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (tx_wr_en) begin
      echo_cnt++;
      if (q_echo.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL echo_unexpected: got %0h expected none", tx_data);
      end else begin
        chk("echo", 64'(tx_data), 64'(q_echo.pop_front()));
      end
    end
    if (imem_we) begin
      if (q_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL we_unexpected: got %0h@%0h expected none",
                 imem_wdata, imem_addr);
      end else begin
        chk("imem_write", 64'({imem_addr, imem_wdata}),
            64'(q_wr.pop_front()));
      end
    end
  end

  function automatic vec_t mk(input logic [7:0] ch, input logic [7:0] e,
                              input bit we, input logic [35:0] wr,
                              input bit er, input int lc);
    vec_t v;
    v.ch = ch; v.echo = e; v.we = we; v.wr = wr; v.err = er; v.lc = lc;
    return v;
  endfunction

  function automatic logic [7:0] hexch(input logic [3:0] n, input bit low);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (low ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  task automatic send(input logic [7:0] b);
    int n;
    int e0;
    e0 = echo_cnt;
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    n = 0;
    while (!rx_rdy_clr && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_clr_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1 rx_rdy = 1'b0;
    n = 0;
    while (echo_cnt == e0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("echo_timeout", 64'(n), 64'(0));
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [3:0] a,
                           input bit low);
    logic [7:0] c;
    for (int k = 7; k >= 0; k--) begin
      c = hexch(w[4*k +: 4], low);
      q_echo.push_back(c);
      if (k == 0) q_wr.push_back({a, w});
      send(c);
    end
  endtask

  function automatic logic [63:0] outs();
    return {15'h0, rx_rdy_clr, tx_data, tx_wr_en, imem_we, imem_addr,
            imem_wdata, cpu_start, load_count, err};
  endfunction

  initial begin
    int e0;
    int n;
    logic [31:0] w;

    tv.push_back(mk(8'h30, 8'h30, 0, '0, 0, 0));
    tv.push_back(mk(8'h30, 8'h30, 0, '0, 0, 0));
    tv.push_back(mk(8'h33, 8'h33, 0, '0, 0, 0));
    tv.push_back(mk(8'h30, 8'h30, 0, '0, 0, 0));
    tv.push_back(mk(8'h30, 8'h30, 0, '0, 0, 0));
    tv.push_back(mk(8'h31, 8'h31, 0, '0, 0, 0));
    tv.push_back(mk(8'h39, 8'h39, 0, '0, 0, 0));
    tv.push_back(mk(8'h33, 8'h33, 1, {4'h0, 32'h00300193}, 0, 1));
    tv.push_back(mk(8'h61, 8'h61, 0, '0, 0, 1));
    tv.push_back(mk(8'h62, 8'h62, 0, '0, 0, 1));
    tv.push_back(mk(8'h5A, 8'h3F, 0, '0, 1, 1));
    tv.push_back(mk(8'h20, 8'h20, 0, '0, 1, 1));
    tv.push_back(mk(8'h0D, 8'h0D, 0, '0, 1, 1));
    tv.push_back(mk(8'h52, 8'h52, 0, '0, 0, 0));
    tv.push_back(mk(8'h67, 8'h3F, 0, '0, 1, 0));
    tv.push_back(mk(8'h0A, 8'h0A, 0, '0, 1, 0));
    tv.push_back(mk(8'h52, 8'h52, 0, '0, 0, 0));

    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", outs(), 64'h0);

    for (int i = 0; i < tv.size(); i++) begin
      q_echo.push_back(tv[i].echo);
      if (tv[i].we) q_wr.push_back(tv[i].wr);
      send(tv[i].ch);
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(tv[i].err));
      chk($sformatf("vec%0d_lc", i), 64'(load_count), 64'(tv[i].lc));
    end

    // Fill the whole memory, then one digit too many.
    for (int i = 0; i < 16; i++) begin
      w = 32'h1F2E3D00 + 32'(i) * 32'h01010101;
      send_word(w, 4'(i), (i % 2) == 1);
      chk("fill_lc", 64'(load_count), 64'(i + 1));
    end
    q_echo.push_back(8'h21);
    send(8'h31);
    chk("overflow_err", 64'(err), 64'h1);
    chk("overflow_lc", 64'(load_count), 64'd16);
    q_echo.push_back(8'h52);
    send(8'h52);
    chk("clear_lc", 64'(load_count), 64'd0);

    // 'G' timing: clear at t+1, cpu_start visible at t+2.
    q_echo.push_back(8'h47);
    @(negedge clk);
    rx_data = 8'h47;
    rx_rdy  = 1'b1;
    @(negedge clk);
    chk("g_rx_clr_t1", 64'(rx_rdy_clr), 64'h1);
    chk("g_start_t1", 64'(cpu_start), 64'h0);
    @(posedge clk);
    #1 rx_rdy = 1'b0;
    @(negedge clk);
    chk("g_start_t2", 64'(cpu_start), 64'h1);
    chk("g_wr_en_t2", 64'(tx_wr_en), 64'h1);
    repeat (3) @(negedge clk);

    e0 = echo_cnt;
    q_echo.push_back(8'h48);
    cpu_halt = 1'b1;
    repeat (20) @(negedge clk);
    chk("halt_one_echo", 64'(echo_cnt), 64'(e0 + 1));
    chk("halt_start_kept", 64'(cpu_start), 64'h1);
    q_echo.push_back(8'h21);
    send(8'h52);
    chk("r_running_err", 64'(err), 64'h1);
    q_echo.push_back(8'h58);
    send(8'h58);
    chk("x_stop", 64'(cpu_start), 64'h0);
    cpu_halt = 1'b0;

    // Echo held off by a busy transmitter.
    e0 = echo_cnt;
    @(negedge clk);
    tx_busy = 1'b1;
    q_echo.push_back(8'h35);
    rx_data = 8'h35;
    rx_rdy  = 1'b1;
    @(negedge clk);
    chk("busy_rx_clr_t1", 64'(rx_rdy_clr), 64'h1);
    @(posedge clk);
    #1 rx_rdy = 1'b0;
    repeat (50) @(negedge clk);
    chk("busy_held", 64'(echo_cnt), 64'(e0));
    tx_busy = 1'b0;
    n = 0;
    while (echo_cnt == e0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("busy_released", 64'(echo_cnt), 64'(e0 + 1));

    // Reset after five nibbles discards the partial word.
    for (int i = 6; i < 10; i++) begin
      q_echo.push_back(8'h30 + 8'(i));
      send(8'h30 + 8'(i));
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", outs(), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_outs", outs(), 64'h0);
    send_word(32'hDEADBEEF, 4'h0, 1'b0);
    chk("fresh_lc", 64'(load_count), 64'h1);

    repeat (5) @(negedge clk);
    chk("echo_queue_empty", 64'(q_echo.size()), 64'h0);
    chk("write_queue_empty", 64'(q_wr.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
